// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: word width, RV32I funct3
// access-size codes and the IDLE/WAIT/RESP state encoding.
// No ports; imported by the interface, the lane unit and the top.
package mem_responder_pkg;

  localparam int WORD_W = 32;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a controller (master) and the responder (slave).
// Request: req, we, addr, wdata, funct3. Response: ready, rdata, err, busy.
// No flow control beyond busy: requests seen while busy are dropped, not queued.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [2:0]        funct3;
  logic              ready;
  logic [WORD_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, funct3,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output ready, rdata, err, busy
  );

endinterface

// File: rtl/mem_responder_byte_lane_unit.sv
// Byte-lane steering: load align/extend, store byte enables with replicated
// write data, and misaligned / illegal access detection. Purely combinational.
// Ports: we_i, off_i (addr[1:0]), funct3_i, wdata_i, rword_i (addressed word) ->
//        rdata_o, be_o, wdata_o, misalign_o, illegal_o.
module byte_lane_unit
  import mem_responder_pkg::*;
(
  input  logic              we_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        funct3_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] rword_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [3:0]        be_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic              misalign_o,
  output logic              illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    rdata_o    = '0;
    be_o       = '0;
    wdata_o    = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;

    byte_sel = rword_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];

    // funct3[1:0] encodes the size for both loads and stores
    case (funct3_i[1:0])
      2'b01:   misalign_o = off_i[0];
      2'b10:   misalign_o = (off_i != 2'b00);
      default: misalign_o = 1'b0;
    endcase

    // Size 11 never exists; unsigned variants only exist for byte/half loads
    illegal_o = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110) ||
                (we_i && funct3_i[2]);

    case (funct3_i)
      LB:      rdata_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      rdata_o = {{16{half_sel[15]}}, half_sel};
      LW:      rdata_o = rword_i;
      LBU:     rdata_o = {24'h0, byte_sel};
      LHU:     rdata_o = {16'h0, half_sel};
      default: rdata_o = '0;
    endcase

    if (we_i) begin
      case (funct3_i)
        SB: begin
          be_o    = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SH: begin
          be_o    = off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        SW: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
        default: begin
          be_o    = '0;
          wdata_o = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word-array memory responder for a multicycle RV32I core.
// Latency: ready pulses LATENCY+1 cycles after the accept edge (one-cycle RESP).
// Backpressure: none; req is only sampled in IDLE, busy flags WAIT/RESP.
// Ports: clk, rst (async, active-high), bus (mem_responder_if.slave).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
)(
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [WORD_W-1:0] rdata_hold_q, rdata_hold_d;

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic              in_range;
  logic [IDX_W-1:0]  word_idx;
  logic [WORD_W-1:0] rword;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] st_data;
  logic [3:0]        be;
  logic              misalign;
  logic              illegal;
  logic              acc_err;
  logic              in_resp;
  logic              wr_en;
  logic [WORD_W-1:0] resp_data;

  assign in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
  assign word_idx = addr_q[IDX_W+1:2];
  // Gate the read so an out-of-range address never indexes past the array
  assign rword    = in_range ? mem_q[word_idx] : '0;

  byte_lane_unit u_lane (
    .we_i       (we_q),
    .off_i      (addr_q[1:0]),
    .funct3_i   (f3_q),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .rdata_o    (load_data),
    .be_o       (be),
    .wdata_o    (st_data),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  assign acc_err = !in_range || misalign || illegal;
  assign in_resp = (state_q == ST_RESP);
  assign wr_en   = in_resp && we_q && !acc_err;

  // Errors force zero; stores leave the last load result in place
  always_comb begin
    resp_data = rdata_hold_q;
    if (acc_err)    resp_data = '0;
    else if (!we_q) resp_data = load_data;
  end

  assign bus.ready = in_resp;
  assign bus.err   = in_resp && acc_err;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.rdata = in_resp ? resp_data : rdata_hold_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    rdata_hold_d = rdata_hold_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          f3_d    = bus.funct3;
          cnt_d   = LAT_C;
          state_d = (LAT_C == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leaving on count 1 gives exactly LATENCY WAIT cycles
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        rdata_hold_d = resp_data;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f3_q         <= f3_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // Array has no reset; reset aborts RESP so a pending store never lands
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the selected bus; returns response data, err and the
  // cycle number (1 = first cycle after the accept edge) on which ready was seen.
  task automatic access(input bit use0, input bit we_v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic e, output int cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((use0 ? bus0.busy : bus.busy) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (use0) begin
      bus0.req = 1'b1; bus0.we = we_v; bus0.addr = a; bus0.wdata = wd; bus0.funct3 = f3;
    end else begin
      bus.req = 1'b1; bus.we = we_v; bus.addr = a; bus.wdata = wd; bus.funct3 = f3;
    end
    @(posedge clk); #1;
    if (use0) bus0.req = 1'b0; else bus.req = 1'b0;
    cyc = 1;
    check("busy_after_accept", 32'(use0 ? bus0.busy : bus.busy), 32'd1);
    while (!(use0 ? bus0.ready : bus.ready) && cyc < 20) begin
      check("err_low_without_ready", 32'(use0 ? bus0.err : bus.err), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_in_resp", 32'(use0 ? bus0.busy : bus.busy), 32'd1);
    rd = use0 ? bus0.rdata : bus.rdata;
    e  = use0 ? bus0.err : bus.err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          cyc;
    int          nrdy;

    bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;  bus.funct3 = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.funct3 = '0;

    // Reset state
    #12;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_rdata", bus.rdata,      32'h0);
    check("rst_cnt",   32'(dut.cnt_q), 32'd0);
    rst = 1'b0;

    // Store then load, LATENCY=2 -> ready on cycle 3
    access(0, 1, 32'h10, 32'hDEADBEEF, SW, rd, e, cyc);
    check("sw_latency", 32'(cyc), 32'd3);
    check("sw_err",     32'(e),   32'd0);
    check("sw_rdata_unchanged", rd, 32'h0);
    access(0, 0, 32'h10, 32'h0, LW, rd, e, cyc);
    check("lw_latency", 32'(cyc), 32'd3);
    check("lw_rdata",   rd,       32'hDEADBEEF);
    check("lw_err",     32'(e),   32'd0);
    // rdata held after ready drops
    @(posedge clk); #1;
    check("rdata_held", bus.rdata, 32'hDEADBEEF);
    access(0, 1, 32'h14, 32'h01020304, SW, rd, e, cyc);
    check("sw_keeps_last_load", rd, 32'hDEADBEEF);

    // Byte/half loads
    access(0, 1, 32'h10, 32'h80FF7F01, SW, rd, e, cyc);
    access(0, 0, 32'h13, 32'h0, LB,  rd, e, cyc); check("lb_13",  rd, 32'hFFFFFF80);
    access(0, 0, 32'h13, 32'h0, LBU, rd, e, cyc); check("lbu_13", rd, 32'h00000080);
    access(0, 0, 32'h12, 32'h0, LH,  rd, e, cyc); check("lh_12",  rd, 32'hFFFF80FF);
    access(0, 0, 32'h10, 32'h0, LHU, rd, e, cyc); check("lhu_10", rd, 32'h00007F01);
    access(0, 0, 32'h11, 32'h0, LB,  rd, e, cyc); check("lb_11",  rd, 32'h0000007F);
    access(0, 0, 32'h12, 32'h0, LBU, rd, e, cyc); check("lbu_12", rd, 32'h000000FF);
    access(0, 0, 32'h10, 32'h0, LH,  rd, e, cyc); check("lh_10",  rd, 32'h00007F01);

    // Partial stores
    access(0, 1, 32'h10, 32'h11223344, SW, rd, e, cyc);
    access(0, 1, 32'h11, 32'h000000AA, SB, rd, e, cyc);
    access(0, 0, 32'h10, 32'h0, LW, rd, e, cyc); check("sb_merge", rd, 32'h1122AA44);
    access(0, 1, 32'h12, 32'h0000BEEF, SH, rd, e, cyc);
    access(0, 0, 32'h10, 32'h0, LW, rd, e, cyc); check("sh_merge", rd, 32'hBEEFAA44);

    // Error cases
    access(0, 0, 32'h12, 32'h0, LW, rd, e, cyc);
    check("lw_mis_err", 32'(e), 32'd1); check("lw_mis_rdata", rd, 32'h0);
    access(0, 1, 32'h20, 32'h55667788, SW, rd, e, cyc);
    access(0, 1, 32'h21, 32'h0000BEEF, SH, rd, e, cyc);
    check("sh_mis_err", 32'(e), 32'd1);
    access(0, 0, 32'h20, 32'h0, LW, rd, e, cyc);
    check("sh_mis_nowrite", rd, 32'h55667788);
    access(0, 0, 32'h400, 32'h0, LW, rd, e, cyc);
    check("oor_err", 32'(e), 32'd1); check("oor_rdata", rd, 32'h0);
    access(0, 0, 32'h3FC, 32'h0, LW, rd, e, cyc);
    check("last_word_ok", 32'(e), 32'd0);
    access(0, 0, 32'h20, 32'h0, 3'b011, rd, e, cyc);
    check("f3_011_err", 32'(e), 32'd1);
    access(0, 1, 32'h20, 32'hFFFFFFFF, 3'b100, rd, e, cyc);
    check("st_f3u_err", 32'(e), 32'd1);
    access(0, 0, 32'h20, 32'h0, LW, rd, e, cyc);
    check("st_f3u_nowrite", rd, 32'h55667788);

    // LATENCY=0 instance
    access(1, 1, 32'h40, 32'hA5A5_5A5A, SW, rd, e, cyc);
    check("l0_sw_latency", 32'(cyc), 32'd1);
    access(1, 0, 32'h40, 32'h0, LW, rd, e, cyc);
    check("l0_lw_latency", 32'(cyc), 32'd1);
    check("l0_lw_rdata", rd, 32'hA5A55A5A);

    // req held high: one response per IDLE accept, busy pattern 1,1,1,0 repeating
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.funct3 = LW;
    nrdy = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.ready) nrdy++;
      check("held_busy", 32'(bus.busy), (k % 4 == 0) ? 32'd0 : 32'd1);
    end
    bus.req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.ready) nrdy++;
    end
    check("held_resp_count", 32'(nrdy), 32'd2);

    // Reset during WAIT aborts a store
    access(0, 1, 32'h30, 32'hCAFEF00D, SW, rd, e, cyc);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h30; bus.wdata = 32'h12345678; bus.funct3 = SW;
    @(posedge clk); #1;
    bus.req = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_rdata", bus.rdata, 32'h0);
    #2;
    rst = 1'b0;
    nrdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.ready) nrdy++;
    end
    check("midrst_no_ready", 32'(nrdy), 32'd0);
    access(0, 0, 32'h30, 32'h0, LW, rd, e, cyc);
    check("midrst_nowrite", rd, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
